// File: rtl/shift_add_mult.sv
// Sequencer for a serial shift-add multiplier: accepts one operand pair, runs the
// multiplier for N enable cycles, lets it settle, then hands the product downstream.
module shift_add_mult_ctrl #(
    parameter int N      = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_a,
    input  logic [N-1:0]       in_b,
    output logic [N-1:0]       mult_parallel,
    output logic [N-1:0]       mult_serial,
    output logic               mult_en,
    input  logic [2*N-1:0]     mult_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*N-1:0]     out_product,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count,
    output logic [2:0]         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; valid never depends on ready, and the payload is held while valid waits.

    localparam int RUN_W = $clog2(N + 1);
    localparam int SET_W = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_RUN     = 3'd2,
        S_SETTLE  = 3'd3,
        S_CAPTURE = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [RUN_W-1:0]   run_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               accept;
    logic               handoff;

    assign accept    = (state == S_IDLE) && in_valid && in_ready;
    assign handoff   = (state == S_HOLD) && out_valid && out_ready;
    assign dbg_state = state;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (accept) next_state = S_LOAD;
            S_LOAD:    next_state = S_RUN;
            S_RUN:     if (run_cnt == RUN_W'(N - 1)) next_state = S_SETTLE;
            S_SETTLE:  if (settle_cnt == SET_W'(SETTLE - 1)) next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_HOLD;
            S_HOLD:    if (handoff) next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Every output is a flop loaded from next_state, so the ports never glitch
    // and reset drops mult_en/out_valid asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            run_cnt       <= '0;
            settle_cnt    <= '0;
            in_ready      <= 1'b0;
            mult_en       <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            mult_parallel <= '0;
            mult_serial   <= '0;
            out_product   <= '0;
            op_count      <= '0;
        end else begin
            state      <= next_state;
            run_cnt    <= (state == S_RUN && next_state == S_RUN) ? run_cnt + RUN_W'(1) : '0;
            settle_cnt <= (state == S_SETTLE && next_state == S_SETTLE) ?
                          settle_cnt + SET_W'(1) : '0;
            in_ready   <= (next_state == S_IDLE);
            mult_en    <= (next_state == S_RUN);
            out_valid  <= (next_state == S_HOLD);
            busy       <= (next_state != S_IDLE);
            if (accept) begin
                mult_parallel <= in_a;
                mult_serial   <= in_b;
            end
            if (state == S_CAPTURE) begin
                out_product <= mult_product;
            end
            if (handoff) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl with a behavioural shift-add multiplier attached;
// results are checked against a queue of expected products.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [3:0]  mult_parallel;
    logic [3:0]  mult_serial;
    logic        mult_en;
    logic [7:0]  mult_product;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_product;
    logic        busy;
    logic [15:0] op_count;
    logic [2:0]  dbg_state;

    int          total = 0;
    int          passed = 0;
    int          fails = 0;
    logic [15:0] model_ops = '0;
    logic [7:0]  exp_q[$];

    shift_add_mult_ctrl #(.N(4), .SETTLE(1), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .mult_parallel (mult_parallel),
        .mult_serial   (mult_serial),
        .mult_en       (mult_en),
        .mult_product  (mult_product),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_product   (out_product),
        .busy          (busy),
        .op_count      (op_count),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Multiplier model: one serial bit per enabled cycle, product complete after 4.
    logic [7:0] acc = '0;
    int         mcnt = 0;
    always @(posedge clk) begin
        if (mult_en) begin
            if (mcnt < 4)
                acc <= ((mcnt == 0) ? 8'd0 : acc) +
                       (mult_serial[mcnt[1:0]] ? (8'(mult_parallel) << mcnt) : 8'd0);
            mcnt <= mcnt + 1;
        end else begin
            mcnt <= 0;
        end
    end
    assign mult_product = acc;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // driver: one full operation, with optional backpressure and stray in_valid
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input int stall,
                          input bit keep_valid, input string tag);
        int         lat;
        int         en_cycles;
        bit         ok_ready, ok_ops, ok_busy, ok_hold;
        logic [7:0] exp;
        out_ready = (stall == 0);
        wait_ready(tag);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        step();
        exp_q.push_back(8'(a) * 8'(b));
        if (keep_valid) begin
            in_a = ~a;
            in_b = b + 4'd3;
        end else begin
            in_valid = 1'b0;
        end
        check({tag, "_par"}, 32'(mult_parallel), 32'(a));
        check({tag, "_ser"}, 32'(mult_serial), 32'(b));
        lat = 0; en_cycles = 0;
        ok_ready = 1; ok_ops = 1; ok_busy = 1;
        while (!out_valid && lat < 40) begin
            if (mult_en) en_cycles++;
            if (in_ready) ok_ready = 0;
            if (!busy) ok_busy = 0;
            if (mult_parallel !== a || mult_serial !== b) ok_ops = 0;
            step();
            lat++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'd7);
        check({tag, "_en_cycles"}, 32'(en_cycles), 32'd4);
        check({tag, "_in_ready_low"}, 32'(ok_ready), 32'd1);
        check({tag, "_busy"}, 32'(ok_busy), 32'd1);
        check({tag, "_ops_stable"}, 32'(ok_ops), 32'd1);
        exp = exp_q.pop_front();
        ok_hold = 1;
        for (int i = 0; i < stall; i++) begin
            if (!out_valid || out_product !== exp || in_ready || op_count !== model_ops)
                ok_hold = 0;
            step();
        end
        if (stall > 0) check({tag, "_hold"}, 32'(ok_hold), 32'd1);
        out_ready = 1'b1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_product"}, 32'(out_product), 32'(exp));
        step();
        model_ops = model_ops + 16'd1;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_op_count"}, 32'(op_count), 32'(model_ops));
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mult_en", 32'(mult_en), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_par", 32'(mult_parallel), 32'd0);
        check("rst_ser", 32'(mult_serial), 32'd0);
        check("rst_product", 32'(out_product), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // T1
        run_op(4'hA, 4'h9, 0, 0, "t1");
        // T2
        run_op(4'hF, 4'hF, 0, 0, "t2_max");
        run_op(4'h0, 4'h7, 0, 0, "t2_zero");
        // T3
        run_op(4'h6, 4'hB, 10, 0, "t3");
        // T4
        run_op(4'h5, 4'hC, 0, 1, "t4");

        // T5: reset during the second RUN cycle
        out_ready = 1'b1;
        wait_ready("t5");
        in_a = 4'hC; in_b = 4'hD; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("t5_running", 32'(mult_en), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_en", 32'(mult_en), 32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        model_ops = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t5_ready", 32'(in_ready), 32'd1);
        begin
            bit no_out = 1;
            for (int i = 0; i < 10; i++) begin
                if (out_valid || busy) no_out = 0;
                step();
            end
            check("t5_no_result", 32'(no_out), 32'd1);
        end
        check("t5_op_count", 32'(op_count), 32'd0);
        run_op(4'h3, 4'h5, 0, 0, "t5_new");

        // T6: random back-to-back traffic
        for (int k = 0; k < 20; k++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), 0, "t6");
        end
        check("t6_op_count", 32'(op_count), 32'd21);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        // report
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
